regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_sb.sv | 93 +++++++++
 tb/tb_regfile_sb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared parameter defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_ADDR_SIZE  = 5;
    localparam int DEF_WORD_SIZE  = 32;
    localparam int DEF_READ_PORTS = 2;
    localparam int DEF_ZERO_REG   = 1;
    localparam int DEF_BYPASS     = 1;

    // Low bit of port `port` inside a packed bus of `width`-bit slices.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking outstanding long-latency producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int ZERO_REG  = DEF_ZERO_REG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_we,
    input  logic [ADDR_SIZE-1:0]  d_addr,
    input  logic                  res_valid,
    input  logic [ADDR_SIZE-1:0]  res_addr,
    output logic [2**ADDR_SIZE-1:0] busy,
    output logic                  res_ready,
    output logic                  res_set,
    output logic [ADDR_SIZE:0]    busy_count
);

    localparam int DEPTH = 2**ADDR_SIZE;

    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [ADDR_SIZE:0] count_q, count_d;
    logic               wr_en, same, inc, dec;

    // Next busy vector and incremental population count; a same-address
    // write plus accepted reservation leaves the bit set.
    always_comb begin
        wr_en     = d_we && !(ZERO_REG != 0 && d_addr == '0);
        res_ready = !busy_q[res_addr] || (d_we && d_addr == res_addr);
        res_set   = res_valid && res_ready && !(ZERO_REG != 0 && res_addr == '0);
        same      = wr_en && res_set && (d_addr == res_addr);
        inc       = res_set && !busy_q[res_addr];
        dec       = wr_en && busy_q[d_addr] && !same;

        busy_d = busy_q;
        if (wr_en) busy_d[d_addr] = 1'b0;
        if (res_set) busy_d[res_addr] = 1'b1;

        count_d = count_q;
        if (inc && !dec) count_d = count_q + (ADDR_SIZE+1)'(1);
        else if (dec && !inc) count_d = count_q - (ADDR_SIZE+1)'(1);
    end

    // Busy state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional zero register, write bypass and
// a reservation scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int READ_PORTS = DEF_READ_PORTS,
    parameter int ZERO_REG   = DEF_ZERO_REG,
    parameter int BYPASS     = DEF_BYPASS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [READ_PORTS*ADDR_SIZE-1:0]  rd_addr,
    output logic [READ_PORTS*WORD_SIZE-1:0]  rd_data,
    output logic [READ_PORTS-1:0]            rd_busy,
    input  logic                             d_we,
    input  logic [ADDR_SIZE-1:0]             d_addr,
    input  logic [WORD_SIZE-1:0]             d_data,
    input  logic                             res_valid,
    input  logic [ADDR_SIZE-1:0]             res_addr,
    output logic                             res_ready,
    output logic [ADDR_SIZE:0]               busy_count
);

    localparam int DEPTH = 2**ADDR_SIZE;

    logic [WORD_SIZE-1:0] regs_q [DEPTH];
    logic [WORD_SIZE-1:0] regs_d [DEPTH];
    logic                 wr_en;
    logic [DEPTH-1:0]     busy;
    logic                 res_set;

    regfile_scoreboard #(
        .ADDR_SIZE (ADDR_SIZE),
        .ZERO_REG  (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .res_valid  (res_valid),
        .res_addr   (res_addr),
        .busy       (busy),
        .res_ready  (res_ready),
        .res_set    (res_set),
        .busy_count (busy_count)
    );

    // Next data array contents; the zero register is never written.
    always_comb begin
        wr_en  = d_we && !(ZERO_REG != 0 && d_addr == '0);
        regs_d = regs_q;
        if (wr_en) regs_d[d_addr] = d_data;
    end

    // Data array register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    // Combinational read ports with forwarding of the in-flight write.
    always_comb begin
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
        logic                 hit;
        logic                 busy_bit;
        rd_data  = '0;
        rd_busy  = '0;
        addr     = '0;
        data     = '0;
        hit      = 1'b0;
        busy_bit = 1'b0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            addr = rd_addr[slice_lo(p, ADDR_SIZE) +: ADDR_SIZE];
            hit  = (BYPASS != 0) && wr_en && (d_addr == addr);
            if (ZERO_REG != 0 && addr == '0) begin
                data     = '0;
                busy_bit = 1'b0;
            end else if (hit) begin
                data     = d_data;
                busy_bit = res_set && (res_addr == addr);
            end else begin
                data     = regs_q[addr];
                busy_bit = busy[addr];
            end
            rd_data[slice_lo(p, WORD_SIZE) +: WORD_SIZE] = data;
            rd_busy[p] = busy_bit;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with default parameters.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        d_we;
    logic [4:0]  d_addr;
    logic [31:0] d_data;
    logic        res_valid;
    logic [4:0]  res_addr;
    logic        res_ready;
    logic [5:0]  busy_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_data     (d_data),
        .res_valid  (res_valid),
        .res_addr   (res_addr),
        .res_ready  (res_ready),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_we = 1'b0; d_addr = '0; d_data = '0;
        res_valid = 1'b0; res_addr = '0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; idle();
        step(); step();
        rst = 1'b0;
        rd_addr = {5'd6, 5'd5};
        #1;
        check("rst_count", 64'(busy_count), 64'd0);
        check("rst_ready", 64'(res_ready), 64'd1);
        check("rst_busy", 64'(rd_busy), 64'd0);
        check("rst_data", rd_data, 64'd0);

        // write reg 5, read on both ports next cycle
        d_we = 1'b1; d_addr = 5'd5; d_data = 32'hDEADBEEF; rd_addr = '0;
        step(); idle();
        rd_addr = {5'd5, 5'd5};
        #1;
        check("r5_data", rd_data, 64'hDEADBEEF_DEADBEEF);
        check("r5_busy", 64'(rd_busy), 64'd0);
        check("r5_count", 64'(busy_count), 64'd0);

        // zero register: no write, no bypass, no reservation
        d_we = 1'b1; d_addr = 5'd0; d_data = 32'h12345678; rd_addr = {5'd5, 5'd0};
        #1;
        check("r0_nobypass", rd_data, 64'hDEADBEEF_00000000);
        step(); idle();
        #1;
        check("r0_read", rd_data, 64'hDEADBEEF_00000000);
        res_valid = 1'b1; res_addr = 5'd0;
        #1;
        check("r0_ready", 64'(res_ready), 64'd1);
        step(); idle();
        #1;
        check("r0_count", 64'(busy_count), 64'd0);
        check("r0_busy", 64'(rd_busy), 64'd0);

        // bypass on port 0, port 1 reads stored reg 5
        d_we = 1'b1; d_addr = 5'd7; d_data = 32'hA5A5A5A5; rd_addr = {5'd5, 5'd7};
        #1;
        check("byp_data", rd_data, 64'hDEADBEEF_A5A5A5A5);
        check("byp_busy", 64'(rd_busy), 64'd0);
        step(); idle();
        #1;
        check("r7_stored", rd_data, 64'hDEADBEEF_A5A5A5A5);

        // reserve reg 3, stall a second reservation, clear by write
        res_valid = 1'b1; res_addr = 5'd3;
        #1;
        check("r3_ready1", 64'(res_ready), 64'd1);
        step();
        rd_addr = {5'd3, 5'd3};
        #1;
        check("r3_busy", 64'(rd_busy), 64'd3);
        check("r3_count1", 64'(busy_count), 64'd1);
        check("r3_ready2", 64'(res_ready), 64'd0);
        step(); idle();
        #1;
        check("r3_stall_count", 64'(busy_count), 64'd1);
        d_we = 1'b1; d_addr = 5'd3; d_data = 32'h33; res_addr = 5'd3;
        #1;
        check("r3_wr_ready", 64'(res_ready), 64'd1);
        check("r3_byp_busy", 64'(rd_busy), 64'd0);
        step(); idle();
        #1;
        check("r3_cleared", 64'(rd_busy), 64'd0);
        check("r3_count0", 64'(busy_count), 64'd0);
        check("r3_data", rd_data, 64'h00000033_00000033);

        // same-cycle write and reservation to reg 9: reservation wins
        d_we = 1'b1; d_addr = 5'd9; d_data = 32'h55;
        res_valid = 1'b1; res_addr = 5'd9; rd_addr = {5'd3, 5'd9};
        #1;
        check("r9_byp_data", rd_data, 64'h00000033_00000055);
        check("r9_byp_busy", 64'(rd_busy), 64'd1);
        step(); idle();
        #1;
        check("r9_data", rd_data, 64'h00000033_00000055);
        check("r9_busy", 64'(rd_busy), 64'd1);
        check("r9_count", 64'(busy_count), 64'd1);

        // write+reserve again on a busy reg 9: bit stays, count unchanged
        d_we = 1'b1; d_addr = 5'd9; d_data = 32'h66;
        res_valid = 1'b1; res_addr = 5'd9;
        #1;
        check("r9_again_ready", 64'(res_ready), 64'd1);
        step(); idle();
        #1;
        check("r9_again_count", 64'(busy_count), 64'd1);
        check("r9_again_data", rd_data, 64'h00000033_00000066);

        // write 9 (clears) while reserving 10 (sets): count stays 1
        d_we = 1'b1; d_addr = 5'd9; d_data = 32'h77;
        res_valid = 1'b1; res_addr = 5'd10;
        step(); idle();
        rd_addr = {5'd10, 5'd9};
        #1;
        check("swap_busy", 64'(rd_busy), 64'd2);
        check("swap_count", 64'(busy_count), 64'd1);

        // reserve 1, 2, 4 then reset with a concurrent write and reservation
        res_valid = 1'b1;
        res_addr = 5'd1; step();
        res_addr = 5'd2; step();
        res_addr = 5'd4; step();
        idle();
        #1;
        check("multi_count", 64'(busy_count), 64'd4);
        rst = 1'b1;
        d_we = 1'b1; d_addr = 5'd6; d_data = 32'hFF;
        res_valid = 1'b1; res_addr = 5'd6;
        step();
        rst = 1'b0; idle();
        res_addr = 5'd1;
        rd_addr = {5'd9, 5'd5};
        #1;
        check("post_rst_count", 64'(busy_count), 64'd0);
        check("post_rst_ready", 64'(res_ready), 64'd1);
        check("post_rst_data", rd_data, 64'd0);
        rd_addr = {5'd6, 5'd1};
        #1;
        check("post_rst_busy", 64'(rd_busy), 64'd0);
        check("post_rst_r6", rd_data[63:32], 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
